// File: rtl/conv_loop_sequencer_if.sv
// conv_loop_sequencer_if
//
// Purpose: groups the control, issue, pipeline-strobe and result signals of
// the convolution loop sequencer into one bundle.
//
// Signals:
//   start, data_ready           - driven by the controlling side
//   running, done               - pass status
//   int_mem_re, ky..x           - issue stage (memory read + loop indices)
//   write_a, write_b, in_bounds - capture stage strobes
//   mac_valid,
//   mac_accumulate_with_0       - MAC stage strobes
//   output_valid, output_x/y/ch - final result strobe and coordinates
//   busy_cycles                 - optional performance counter
//
// Modports: master = sequencer side, slave = consumer / controller side.
interface conv_loop_sequencer_if #(
    parameter int FEATURE_MAP_WIDTH  = 128,
    parameter int FEATURE_MAP_HEIGHT = 128,
    parameter int OUTPUT_NB_CHANNELS = 16
);
    localparam int X_W  = (FEATURE_MAP_WIDTH  > 1) ? $clog2(FEATURE_MAP_WIDTH)  : 1;
    localparam int Y_W  = (FEATURE_MAP_HEIGHT > 1) ? $clog2(FEATURE_MAP_HEIGHT) : 1;
    localparam int CH_W = (OUTPUT_NB_CHANNELS > 1) ? $clog2(OUTPUT_NB_CHANNELS) : 1;

    logic            start;
    logic            data_ready;
    logic            running;
    logic            done;
    logic            int_mem_re;
    logic [31:0]     ky;
    logic [31:0]     kx;
    logic [31:0]     inch;
    logic [31:0]     outch;
    logic [31:0]     y;
    logic [31:0]     x;
    logic            write_a;
    logic            write_b;
    logic            in_bounds;
    logic            mac_valid;
    logic            mac_accumulate_with_0;
    logic            output_valid;
    logic [X_W-1:0]  output_x;
    logic [Y_W-1:0]  output_y;
    logic [CH_W-1:0] output_ch;
    logic [31:0]     busy_cycles;

    modport master (
        input  start, data_ready,
        output running, done, int_mem_re,
        output ky, kx, inch, outch, y, x,
        output write_a, write_b, in_bounds,
        output mac_valid, mac_accumulate_with_0,
        output output_valid, output_x, output_y, output_ch,
        output busy_cycles
    );

    modport slave (
        output start, data_ready,
        input  running, done, int_mem_re,
        input  ky, kx, inch, outch, y, x,
        input  write_a, write_b, in_bounds,
        input  mac_valid, mac_accumulate_with_0,
        input  output_valid, output_x, output_y, output_ch,
        input  busy_cycles
    );
endinterface

// File: rtl/conv_loop_sequencer.sv
// conv_loop_sequencer
//
// Purpose: walks the six nested convolution loops (y, x, outch, inch, ky, kx,
// outermost first), issuing one memory read per cycle while data_ready is
// high, and runs a three-stage strobe pipeline behind the issue stage:
//   t   : issue        (int_mem_re, indices)
//   t+1 : capture      (write_a, write_b, in_bounds)
//   t+2 : MAC          (mac_valid, mac_accumulate_with_0)
//   t+3 : result       (output_valid, output_x/y/ch) for the last term of a sum
// data_ready only gates issue; stages already in flight keep moving.
//
// Ports:
//   clk     - clock, rising edge
//   arst_in - asynchronous active-high reset
//   bus     - conv_loop_sequencer_if.master (all other signals)
//
// Optional feature: define SEQ_PERF_COUNT_EN to build the saturating
// busy_cycles counter (cycles with running=1); otherwise busy_cycles is 0.
module conv_loop_sequencer #(
    parameter int FEATURE_MAP_WIDTH  = 128,
    parameter int FEATURE_MAP_HEIGHT = 128,
    parameter int INPUT_NB_CHANNELS  = 2,
    parameter int OUTPUT_NB_CHANNELS = 16,
    parameter int KERNEL_SIZE        = 3
) (
    input  logic                  clk,
    input  logic                  arst_in,
    conv_loop_sequencer_if.master bus
);
    localparam int X_W   = (FEATURE_MAP_WIDTH  > 1) ? $clog2(FEATURE_MAP_WIDTH)  : 1;
    localparam int Y_W   = (FEATURE_MAP_HEIGHT > 1) ? $clog2(FEATURE_MAP_HEIGHT) : 1;
    localparam int CH_W  = (OUTPUT_NB_CHANNELS > 1) ? $clog2(OUTPUT_NB_CHANNELS) : 1;
    localparam int NLOOP = 6;

    // Loop levels, innermost first: 0=kx 1=ky 2=inch 3=outch 4=x 5=y
    localparam int L_KX = 0;
    localparam int L_KY = 1;
    localparam int L_IC = 2;
    localparam int L_OC = 3;
    localparam int L_X  = 4;
    localparam int L_Y  = 5;

    localparam logic signed [33:0] HALF_K = 34'(KERNEL_SIZE / 2);
    localparam logic signed [33:0] MAP_W  = 34'(FEATURE_MAP_WIDTH);
    localparam logic signed [33:0] MAP_H  = 34'(FEATURE_MAP_HEIGHT);

    function automatic int unsigned loop_limit(input int level);
        case (level)
            0:       return KERNEL_SIZE;
            1:       return KERNEL_SIZE;
            2:       return INPUT_NB_CHANNELS;
            3:       return OUTPUT_NB_CHANNELS;
            4:       return FEATURE_MAP_WIDTH;
            default: return FEATURE_MAP_HEIGHT;
        endcase
    endfunction

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t     state_reg;
    state_t     state_next;
    logic [1:0] drain_cnt_reg;
    logic [1:0] drain_cnt_next;

    logic [NLOOP-1:0][31:0] idx_reg;
    logic [NLOOP-1:0]       idx_wrap;
    // carry[i] = level i advances this cycle; carry[NLOOP] = final issue of the pass
    logic [NLOOP:0]         carry;

    logic issue;
    logic running;
    logic last_term;
    logic first_term;
    logic tap_inside;
    logic signed [33:0] tap_y;
    logic signed [33:0] tap_x;

    assign running = (state_reg == RUN) || (state_reg == DRAIN);
    assign issue   = (state_reg == RUN) && bus.data_ready;
    assign carry[0] = issue;

    // Odometer: each level steps when every inner level wraps. After the
    // final issue every level has wrapped, so indices are 0 entering DRAIN.
    generate
        for (genvar gi = 0; gi < NLOOP; gi++) begin : g_loop
            localparam int unsigned LIMIT = loop_limit(gi);

            assign idx_wrap[gi]  = (idx_reg[gi] == 32'(LIMIT - 1));
            assign carry[gi + 1] = carry[gi] & idx_wrap[gi];

            always_ff @(posedge clk or posedge arst_in) begin
                if (arst_in) begin
                    idx_reg[gi] <= '0;
                end else if (carry[gi]) begin
                    idx_reg[gi] <= idx_wrap[gi] ? 32'd0 : idx_reg[gi] + 32'd1;
                end
            end
        end
    endgenerate

    // The last term of a sum is the issue where inch, ky and kx all wrap.
    assign last_term  = carry[L_OC];
    assign first_term = (idx_reg[L_IC] == 32'd0) && (idx_reg[L_KY] == 32'd0) &&
                        (idx_reg[L_KX] == 32'd0);

    // Window tap position relative to the feature map, signed so that the
    // negative half-kernel offset at the top/left edge is detected.
    assign tap_y = $signed({2'b00, idx_reg[L_Y]}) + $signed({2'b00, idx_reg[L_KY]}) - HALF_K;
    assign tap_x = $signed({2'b00, idx_reg[L_X]}) + $signed({2'b00, idx_reg[L_KX]}) - HALF_K;
    assign tap_inside = (tap_y >= 0) && (tap_y < MAP_H) && (tap_x >= 0) && (tap_x < MAP_W);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            state_reg     <= IDLE;
            drain_cnt_reg <= 2'd0;
        end else begin
            state_reg     <= state_next;
            drain_cnt_reg <= drain_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        drain_cnt_next = drain_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (carry[NLOOP]) begin
                    state_next     = DRAIN;
                    drain_cnt_next = 2'd0;
                end
            end
            DRAIN: begin
                // Three cycles: counts 0, 1, 2 then leaves.
                if (drain_cnt_reg == 2'd2) begin
                    state_next = DONE;
                end else begin
                    drain_cnt_next = drain_cnt_reg + 2'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ---------------- strobe pipeline ----------------
    // Stages advance unconditionally; every payload is gated by its valid so
    // an empty stage presents all zeros.
    logic            s1_valid_reg;
    logic            s1_in_bounds_reg;
    logic            s1_first_reg;
    logic            s1_last_reg;
    logic [X_W-1:0]  s1_x_reg;
    logic [Y_W-1:0]  s1_y_reg;
    logic [CH_W-1:0] s1_ch_reg;

    logic            s2_valid_reg;
    logic            s2_first_reg;
    logic            s2_last_reg;
    logic [X_W-1:0]  s2_x_reg;
    logic [Y_W-1:0]  s2_y_reg;
    logic [CH_W-1:0] s2_ch_reg;

    logic            s3_valid_reg;
    logic [X_W-1:0]  s3_x_reg;
    logic [Y_W-1:0]  s3_y_reg;
    logic [CH_W-1:0] s3_ch_reg;

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            s1_valid_reg     <= 1'b0;
            s1_in_bounds_reg <= 1'b0;
            s1_first_reg     <= 1'b0;
            s1_last_reg      <= 1'b0;
            s1_x_reg         <= '0;
            s1_y_reg         <= '0;
            s1_ch_reg        <= '0;
            s2_valid_reg     <= 1'b0;
            s2_first_reg     <= 1'b0;
            s2_last_reg      <= 1'b0;
            s2_x_reg         <= '0;
            s2_y_reg         <= '0;
            s2_ch_reg        <= '0;
            s3_valid_reg     <= 1'b0;
            s3_x_reg         <= '0;
            s3_y_reg         <= '0;
            s3_ch_reg        <= '0;
        end else begin
            s1_valid_reg     <= issue;
            s1_in_bounds_reg <= issue && tap_inside;
            s1_first_reg     <= issue && first_term;
            s1_last_reg      <= last_term;
            s1_x_reg         <= last_term ? idx_reg[L_X][X_W-1:0]   : '0;
            s1_y_reg         <= last_term ? idx_reg[L_Y][Y_W-1:0]   : '0;
            s1_ch_reg        <= last_term ? idx_reg[L_OC][CH_W-1:0] : '0;

            s2_valid_reg     <= s1_valid_reg;
            s2_first_reg     <= s1_first_reg;
            s2_last_reg      <= s1_last_reg;
            s2_x_reg         <= s1_x_reg;
            s2_y_reg         <= s1_y_reg;
            s2_ch_reg        <= s1_ch_reg;

            s3_valid_reg     <= s2_valid_reg && s2_last_reg;
            s3_x_reg         <= s2_x_reg;
            s3_y_reg         <= s2_y_reg;
            s3_ch_reg        <= s2_ch_reg;
        end
    end

    // ---------------- optional busy counter ----------------
`ifdef SEQ_PERF_COUNT_EN
    logic [31:0] busy_reg;

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            busy_reg <= 32'd0;
        end else if ((state_reg == IDLE) && bus.start) begin
            busy_reg <= 32'd0;
        end else if (running && (busy_reg != 32'hFFFF_FFFF)) begin
            busy_reg <= busy_reg + 32'd1;
        end
    end

    assign bus.busy_cycles = busy_reg;
`else
    assign bus.busy_cycles = 32'd0;
`endif

    // ---------------- outputs ----------------
    assign bus.running               = running;
    assign bus.done                  = (state_reg == DONE);
    assign bus.int_mem_re            = issue;
    assign bus.kx                    = idx_reg[L_KX];
    assign bus.ky                    = idx_reg[L_KY];
    assign bus.inch                  = idx_reg[L_IC];
    assign bus.outch                 = idx_reg[L_OC];
    assign bus.x                     = idx_reg[L_X];
    assign bus.y                     = idx_reg[L_Y];
    assign bus.write_a               = s1_valid_reg;
    assign bus.write_b               = s1_valid_reg;
    assign bus.in_bounds             = s1_in_bounds_reg;
    assign bus.mac_valid             = s2_valid_reg;
    assign bus.mac_accumulate_with_0 = s2_first_reg;
    assign bus.output_valid          = s3_valid_reg;
    assign bus.output_x              = s3_x_reg;
    assign bus.output_y              = s3_y_reg;
    assign bus.output_ch             = s3_ch_reg;
endmodule

// File: tb/tb_conv_loop_sequencer.sv
// tb_conv_loop_sequencer
//
// Stimulus process drives start/data_ready/arst_in and, from a nested-loop
// reference model, pushes time-stamped expected events into queues. The
// monitor process samples on the falling edge and compares every strobe,
// index and coordinate against the queue heads.
module tb_conv_loop_sequencer;
    localparam int W   = 2;
    localparam int H   = 2;
    localparam int IN  = 1;
    localparam int OUT = 1;
    localparam int K   = 3;
    localparam int N   = W * H * OUT * IN * K * K;

    typedef struct {
        int y;
        int x;
        int oc;
        int ic;
        int ky;
        int kx;
    } tuple_t;

    typedef struct {
        int cycle;
        int v0;
        int v1;
        int v2;
    } ev_t;

    logic clk = 1'b0;
    logic arst_in = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv_loop_sequencer_if #(
        .FEATURE_MAP_WIDTH (W),
        .FEATURE_MAP_HEIGHT(H),
        .OUTPUT_NB_CHANNELS(OUT)
    ) bus ();

    conv_loop_sequencer #(
        .FEATURE_MAP_WIDTH (W),
        .FEATURE_MAP_HEIGHT(H),
        .INPUT_NB_CHANNELS (IN),
        .OUTPUT_NB_CHANNELS(OUT),
        .KERNEL_SIZE       (K)
    ) dut (
        .clk    (clk),
        .arst_in(arst_in),
        .bus    (bus)
    );

    // Scoreboard state
    tuple_t iss_q[$];
    ev_t    bnd_q[$];
    ev_t    mac_q[$];
    ev_t    out_q[$];
    ev_t    done_q[$];
    bit     exp_re      = 1'b0;
    bit     exp_running = 1'b0;
    int     exp_issues  = 0;
    int     pass_id     = 0;

    // Monitor-owned
    int     checks      = 0;
    int     passed      = 0;
    int     seen_pass   = 0;
    int     issues_seen = 0;
    tuple_t mon_t;
    ev_t    mon_e;
    bit     mon_hit;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (pass_id != seen_pass) begin
            check("issue_count", issues_seen, exp_issues);
            check("queues_drained", iss_q.size() + bnd_q.size() + mac_q.size() +
                  out_q.size() + done_q.size(), 0);
            issues_seen = 0;
            seen_pass   = pass_id;
        end

        check("running", bus.running, exp_running);
        check("int_mem_re", bus.int_mem_re, exp_re);
        if (bus.int_mem_re) issues_seen++;

        // Indices: the next pending issue (held while stalled), 0 otherwise.
        if (iss_q.size() > 0) mon_t = iss_q[0];
        else mon_t = '{default: 0};
        if (exp_re && iss_q.size() > 0) void'(iss_q.pop_front());
        check("idx_y", bus.y, mon_t.y);
        check("idx_x", bus.x, mon_t.x);
        check("idx_outch", bus.outch, mon_t.oc);
        check("idx_inch", bus.inch, mon_t.ic);
        check("idx_ky", bus.ky, mon_t.ky);
        check("idx_kx", bus.kx, mon_t.kx);

        mon_hit = (bnd_q.size() > 0) && (bnd_q[0].cycle == cyc);
        mon_e   = mon_hit ? bnd_q[0] : '{default: 0};
        if (mon_hit) void'(bnd_q.pop_front());
        check("write_a", bus.write_a, mon_hit);
        check("write_b", bus.write_b, mon_hit);
        check("in_bounds", bus.in_bounds, mon_e.v0);

        mon_hit = (mac_q.size() > 0) && (mac_q[0].cycle == cyc);
        mon_e   = mon_hit ? mac_q[0] : '{default: 0};
        if (mon_hit) void'(mac_q.pop_front());
        check("mac_valid", bus.mac_valid, mon_hit);
        check("mac_acc0", bus.mac_accumulate_with_0, mon_e.v0);

        mon_hit = (out_q.size() > 0) && (out_q[0].cycle == cyc);
        mon_e   = mon_hit ? out_q[0] : '{default: 0};
        if (mon_hit) void'(out_q.pop_front());
        check("output_valid", bus.output_valid, mon_hit);
        check("output_x", bus.output_x, mon_e.v0);
        check("output_y", bus.output_y, mon_e.v1);
        check("output_ch", bus.output_ch, mon_e.v2);

        mon_hit = (done_q.size() > 0) && (done_q[0].cycle == cyc);
        mon_e   = done_q.size() > 0 ? done_q[0] : '{default: 0};
        if (mon_hit) void'(done_q.pop_front());
        check("done", bus.done, mon_hit);
        if (mon_hit) check("busy_cycles", bus.busy_cycles, mon_e.v0);
    end

    // One convolution pass. stall_lo..stall_hi: data_ready low (cycles
    // relative to the start cycle). rst_at >= 0: reset asserted at that cycle.
    task automatic run_pass(input int stall_lo, input int stall_hi, input bit rand_dr,
                            input bit noise_start, input int rst_at);
        tuple_t model[$];
        tuple_t t;
        int s0, issued, done_cyc, rel, yy, xx, busy_exp;
        bit dr;

        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                for (int oc = 0; oc < OUT; oc++)
                    for (int ic = 0; ic < IN; ic++)
                        for (int ky = 0; ky < K; ky++)
                            for (int kx = 0; kx < K; kx++)
                                model.push_back('{y, x, oc, ic, ky, kx});

        @(posedge clk); #1;
        s0 = cyc;
        iss_q = model;
        bus.start = 1'b1;
        exp_re = 1'b0;
        exp_running = 1'b0;
        issued = 0;
        done_cyc = -1;

        for (int k = 0; k < 4000; k++) begin
            @(posedge clk); #1;
            rel = cyc - s0;
            bus.start = 1'b0;
            if (rel == rst_at) begin
                arst_in = 1'b1;
                iss_q.delete(); bnd_q.delete(); mac_q.delete();
                out_q.delete(); done_q.delete();
                exp_re = 1'b0;
                exp_running = 1'b0;
                repeat (2) @(posedge clk);
                #1 arst_in = 1'b0;
                bus.data_ready = 1'b1;
                repeat (4) @(posedge clk);
                #1;
                break;
            end
            if (issued < N) begin
                if (rel >= stall_lo && rel <= stall_hi) dr = 1'b0;
                else if (rand_dr) dr = ($urandom_range(0, 3) != 0);
                else dr = 1'b1;
                bus.data_ready = dr;
                exp_running = 1'b1;
                exp_re = dr;
                if (noise_start) bus.start = 1'($urandom_range(0, 1));
                if (dr) begin
                    t  = model[issued];
                    yy = t.y + t.ky - K / 2;
                    xx = t.x + t.kx - K / 2;
                    bnd_q.push_back('{cyc + 1, int'(yy >= 0 && yy < H && xx >= 0 && xx < W), 0, 0});
                    mac_q.push_back('{cyc + 2, int'(t.ic == 0 && t.ky == 0 && t.kx == 0), 0, 0});
                    if (t.ic == IN - 1 && t.ky == K - 1 && t.kx == K - 1)
                        out_q.push_back('{cyc + 3, t.x, t.y, t.oc});
                    issued++;
                    if (issued == N) begin
                        done_cyc = cyc + 4;
`ifdef SEQ_PERF_COUNT_EN
                        busy_exp = done_cyc - s0 - 1;
`else
                        busy_exp = 0;
`endif
                        done_q.push_back('{done_cyc, busy_exp, 0, 0});
                    end
                end
            end else if (cyc < done_cyc) begin
                exp_running = 1'b1;
                exp_re = 1'b0;
                bus.data_ready = 1'($urandom_range(0, 1));
                if (noise_start) bus.start = 1'($urandom_range(0, 1));
            end else if (cyc == done_cyc) begin
                exp_running = 1'b0;
                exp_re = 1'b0;
                bus.start = noise_start;
            end else begin
                exp_running = 1'b0;
                exp_re = 1'b0;
                break;
            end
        end
        exp_issues = issued;
        pass_id++;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.data_ready = 1'b1;
        arst_in = 1'b1;
        repeat (3) @(posedge clk);
        #1 arst_in = 1'b0;
        repeat (2) @(posedge clk);

        run_pass(-1, -1, 1'b0, 1'b0, -1);   // clean pass
        run_pass(5, 9, 1'b0, 1'b0, -1);     // stall window
        run_pass(-1, -1, 1'b0, 1'b0, 20);   // reset mid-pass
        run_pass(-1, -1, 1'b0, 1'b0, -1);   // full pass after reset
        for (int p = 0; p < 3; p++)
            run_pass(-1, -1, 1'b1, 1'b1, -1); // random stalls + stray starts

        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, checks);
        $fatal(1);
    end
endmodule

// File: doc/conv_loop_sequencer.md
CONV_LOOP_SEQUENCER -- requirements
Module: conv_loop_sequencer

Interface
REQ-001 SHALL have parameters, one per line:
- FEATURE_MAP_WIDTH, default 128: output x extent.
- FEATURE_MAP_HEIGHT, default 128: output y extent.
- INPUT_NB_CHANNELS, default 2: input channels.
- OUTPUT_NB_CHANNELS, default 16: output channels.
- KERNEL_SIZE, default 3: odd square kernel size.
REQ-002 SHALL have ports, one per line:
- clk, in, 1: single clock, rising edge.
- arst_in, in, 1: reset, asynchronous, active-high.
- start, in, 1: begin one convolution pass.
- data_ready, in, 1: memory can accept a read this cycle.
- running, out, 1: pass in progress.
- done, out, 1: one-cycle pulse at pass end.
- int_mem_re, out, 1: issue stage, reads input and kernel memories.
- ky, kx, inch, outch, y, x, out, 32 each: issue-stage loop indices.
- write_a, write_b, out, 1: capture stage, loads operand registers.
- in_bounds, out, 1: capture stage, window tap lies inside the feature map.
- mac_valid, out, 1: MAC stage valid.
- mac_accumulate_with_0, out, 1: MAC stage, first term of a sum.
- output_valid, out, 1: MAC result is final.
- output_x, out, clog2(FEATURE_MAP_WIDTH): x index of the final result.
- output_y, out, clog2(FEATURE_MAP_HEIGHT): y index of the final result.
- output_ch, out, clog2(OUTPUT_NB_CHANNELS): channel index of the final result.
- busy_cycles, out, 32: performance counter (see REQ-019).

Function
REQ-003 SHALL nest the loops, outermost first, as y, x, outch, inch, ky, kx; each index counts 0..N-1 and wraps to 0 while carrying into the next outer index.
REQ-004 SHALL implement FSM states IDLE, RUN, DRAIN and DONE:
- IDLE->RUN when start=1.
- RUN->DRAIN in the cycle of the last issue.
- DRAIN->DONE after exactly 3 cycles.
- DONE->IDLE after 1 cycle.
REQ-005 In RUN, the block SHALL issue (int_mem_re=1 and advance indices) in every cycle where data_ready=1; when data_ready=0 it SHALL not issue and SHALL hold the indices.
REQ-006 In-flight pipeline stages SHALL keep advancing while data_ready=0 (stall blocks issue only).
REQ-007 Pipeline timing: an issue at cycle t SHALL give write_a=write_b=1 at t+1, mac_valid=1 at t+2, and output_valid=1 at t+3 if the issue was the last term of its sum.
REQ-008 in_bounds at t+1 SHALL equal 1 iff 0 <= y+ky-KERNEL_SIZE/2 < FEATURE_MAP_HEIGHT and 0 <= x+kx-KERNEL_SIZE/2 < FEATURE_MAP_WIDTH, computed signed at issue t.
REQ-009 mac_accumulate_with_0 SHALL be 1 with mac_valid iff the issue had inch=ky=kx=0.
REQ-010 output_x, output_y and output_ch SHALL carry the x, y and outch of that last-term issue, aligned with output_valid, and SHALL be 0 otherwise.
REQ-011 running SHALL be 1 in RUN and DRAIN; done SHALL be 1 only in DONE.
REQ-012 start SHALL be ignored outside IDLE; start in the DONE cycle SHALL be lost.
REQ-013 Every index SHALL return to 0 on entering DRAIN.
REQ-014 All per-stage strobes SHALL be 0 when the stage holds no issue.
REQ-015 The total number of issues SHALL equal W*H*OUTPUT_NB_CHANNELS*INPUT_NB_CHANNELS*KERNEL_SIZE^2, independent of stalls.

Reset
REQ-016 arst_in=1 SHALL immediately force IDLE, clear all indices and pipeline valids, and drive every output to 0, including mid-pass.
REQ-017 After arst_in deasserts, the block SHALL need a new start; no partial pass SHALL resume.

Configuration
REQ-018 SHALL have one macro, SEQ_PERF_COUNT_EN.
REQ-019 With SEQ_PERF_COUNT_EN defined:
- busy_cycles SHALL count cycles with running=1, saturating at 2^32-1.
- It SHALL clear on the IDLE->RUN transition and on reset, and SHALL hold after done.
Without the macro, busy_cycles SHALL be tied to 0 and no counter SHALL be built.

Verification
REQ-020 Use W=H=2, IN=1, OUT=1, K=3, data_ready=1, start at cycle 0:
- 36 issues in cycles 1..36.
- 4 output_valid pulses at cycles 12, 21, 30, 39, coordinates (0,0), (1,0), (0,1), (1,1).
- done at cycle 40.
- busy_cycles=39 (macro on).
REQ-021 Same setup with data_ready low in cycles 5..9: issues stay 36, done moves to cycle 45, indices are held during the stall, and the in-flight mac_valid pulses at cycles 5 and 6 still occur.
REQ-022 Boundary check: issue y=0, x=0, ky=0, kx=0 -> in_bounds=0; issue y=0, x=0, ky=1, kx=1 -> in_bounds=1.
REQ-023 Assert arst_in at cycle 20 mid-pass -> all outputs 0 within the same cycle, no output_valid or done afterwards; a new start then completes a full 36-issue pass.
REQ-024 start pulses during RUN and DRAIN -> no effect; exactly one done per accepted start.
